// File: rtl/sub_borrow_serial_pkg.sv
// Shared types and helpers for the byte-serial borrow-chained subtractor.
//   BYTE_W    : byte width (fixed at 8 for this revision)
//   state_t   : operation FSM states (IDLE, RUN)
//   subborrow : one byte of subtract-with-borrow; returns the difference
//               byte and hands the borrow out through an output argument.
package sub_borrow_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [BYTE_W-1:0] subborrow(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              bin,
    output logic              bout
  );
    logic [BYTE_W:0] t;
    // One spare bit on top: it goes to 1 exactly when a < b + bin.
    t = {1'b0, a} - {1'b0, b} - {{BYTE_W{1'b0}}, bin};
    bout = t[BYTE_W];
    return t[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/sub_borrow_serial_if.sv
// Operand and result byte streams of the serial subtractor.
//   in_valid/in_ready/in_a/in_b        : operand byte pair stream (LSB first)
//   out_valid/out_ready/out_diff       : difference byte stream
//   out_last/out_borrow                : last-beat marker and final borrow
// Handshake: a beat transfers on a rising clock edge where valid and ready
// are both high. A source holds valid and its data stable until that edge;
// ready may rise or fall at any time and never depends on valid.
interface sub_borrow_serial_if;
  import sub_borrow_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] in_a;
  logic [BYTE_W-1:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic [BYTE_W-1:0] out_diff;
  logic              out_last;
  logic              out_borrow;

  // Subtractor side.
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_diff, out_last, out_borrow
  );

  // Operand source / result sink side.
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_diff, out_last, out_borrow
  );

endinterface

// File: rtl/sub_borrow_serial.sv
// Byte-serial multi-word subtractor with borrow chaining.
// Each operation is WORDS byte pairs, least-significant byte first; each
// accepted pair yields one difference byte one cycle later, and the last
// byte carries the borrow out of the whole operand.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   clear      : synchronous abort; drops any pending byte, keeps op_count
//   io         : operand/result streams (slave modport)
//   op_count   : completed operations, counted when the last byte is consumed
//   state_dbg  : current FSM state
module sub_borrow_serial
  import sub_borrow_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  sub_borrow_serial_if.slave   io,
  output logic [15:0]          op_count,
  output state_t               state_dbg
);

  localparam int unsigned BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [BEAT_W-1:0] beat;
  logic              borrow;
  logic              in_ready;
  logic              accept;
  logic              last_beat;
  logic              bin;
  logic              bout;
  logic [BYTE_W-1:0] diff;

  // Single-entry output register: room exists when it is empty or being
  // drained this cycle. rst_n is folded in so ready stays low during reset.
  assign in_ready    = rst_n && !clear && (!io.out_valid || io.out_ready);
  assign io.in_ready = in_ready;
  assign state_dbg   = state;

  always_comb begin
    bout      = 1'b0;
    accept    = io.in_valid && in_ready;
    last_beat = (beat == LAST_BEAT);
    // Beat 0 starts a fresh operand, so any stale borrow is ignored.
    bin       = (beat == '0) ? 1'b0 : borrow;
    diff      = subborrow(io.in_a, io.in_b, bin, bout);
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else if (accept) begin
      state_nxt = last_beat ? IDLE : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat          <= '0;
      borrow        <= 1'b0;
      io.out_valid  <= 1'b0;
      io.out_diff   <= '0;
      io.out_last   <= 1'b0;
      io.out_borrow <= 1'b0;
    end else if (clear) begin
      beat         <= '0;
      borrow       <= 1'b0;
      io.out_valid <= 1'b0;
    end else if (accept) begin
      beat          <= last_beat ? '0 : beat + BEAT_W'(1);
      borrow        <= last_beat ? 1'b0 : bout;
      io.out_valid  <= 1'b1;
      io.out_diff   <= diff;
      io.out_last   <= last_beat;
      io.out_borrow <= bout && last_beat;
    end else if (io.out_ready) begin
      io.out_valid <= 1'b0;
    end
  end

  // Counted on consumption of the last byte, so a clear that discards a
  // pending last byte does not count it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (!clear && io.out_valid && io.out_ready && io.out_last) begin
      op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_sub_borrow_serial.sv
module tb_sub_borrow_serial;
  import sub_borrow_pkg::*;

  localparam int WORDS = 4;
  localparam int OPW   = WORDS * 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [15:0] op_count;
  state_t      state_dbg;

  sub_borrow_serial_if bus();

  sub_borrow_serial #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .io        (bus),
    .op_count  (op_count),
    .state_dbg (state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // {diff[7:0], last, borrow}
  logic [9:0]  exp_q[$];
  logic [15:0] exp_ops = 16'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-operand subtraction, sliced into per-byte expectations.
  task automatic push_exp(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input int n);
    logic [OPW:0] full;
    full = {1'b0, a} - {1'b0, b};
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({full[i*8 +: 8], (i == WORDS - 1), (i == WORDS - 1) && full[OPW]});
    end
  endtask

  // Driver: present one pair and hold it until accepted.
  task automatic send_beat(input logic [7:0] a, input logic [7:0] b);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 50) check("in_ready_timeout", waited, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_op(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    push_exp(a, b, WORDS);
    for (int i = 0; i < WORDS; i++) send_beat(a[i*8 +: 8], b[i*8 +: 8]);
  endtask

  // Wait for the scoreboard to empty, then for the final consume edge.
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: a byte is consumed on the next edge when valid && ready.
  always @(negedge clk) begin
    if (rst_n && !clear && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_output_byte", {22'd0, bus.out_diff, bus.out_last, bus.out_borrow}, 32'hFFFF_FFFF);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("out_diff",   bus.out_diff,   e[9:2]);
        check("out_last",   bus.out_last,   e[1]);
        check("out_borrow", bus.out_borrow, e[0]);
      end
    end
  end

  initial begin
    logic [OPW-1:0] a, b;
    logic [OPW:0]   full;

    bus.in_valid  = 1'b0;
    bus.in_a      = 8'h00;
    bus.in_b      = 8'h00;
    bus.out_ready = 1'b1;
    clear         = 1'b0;
    rst_n         = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",   bus.in_ready,   0);
    check("rst_out_valid",  bus.out_valid,  0);
    check("rst_out_diff",   bus.out_diff,   0);
    check("rst_out_last",   bus.out_last,   0);
    check("rst_out_borrow", bus.out_borrow, 0);
    check("rst_op_count",   op_count,       0);
    check("rst_state",      32'(state_dbg), 32'(IDLE));
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // 5 - 3, with a look at the FSM after the first beat
    a = 32'h0000_0005; b = 32'h0000_0003;
    push_exp(a, b, WORDS);
    send_beat(a[7:0], b[7:0]);
    check("state_run", 32'(state_dbg), 32'(RUN));
    for (int i = 1; i < WORDS; i++) send_beat(a[i*8 +: 8], b[i*8 +: 8]);
    check("state_idle_after_last", 32'(state_dbg), 32'(IDLE));
    drain();
    exp_ops++;
    check("op_count_t1", op_count, exp_ops);

    // Borrow out of byte 0 absorbed at byte 1
    send_op(32'h0000_0100, 32'h0000_0001);
    drain();
    exp_ops++;
    check("op_count_t2", op_count, exp_ops);

    // Borrow out of the whole operand
    send_op(32'h0000_0000, 32'h0000_0001);
    drain();
    exp_ops++;
    check("op_count_t3", op_count, exp_ops);

    // Backpressure for 3 cycles while beat 2 is waiting
    a = 32'h8000_1234; b = 32'h0000_5678;
    full = {1'b0, a} - {1'b0, b};
    push_exp(a, b, WORDS);
    send_beat(a[7:0],  b[7:0]);
    send_beat(a[15:8], b[15:8]);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = a[23:16];
    bus.in_b      = b[23:16];
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready",  bus.in_ready,  0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_diff",  bus.out_diff,  full[15:8]);
      check("bp_out_last",  bus.out_last,  0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send_beat(a[23:16], b[23:16]);
    send_beat(a[31:24], b[31:24]);
    drain();
    exp_ops++;
    check("op_count_bp", op_count, exp_ops);

    // Clear after beat 1; beat 1's output and the same-cycle beat are dropped
    a = 32'h1234_5678; b = 32'h0000_0001;
    push_exp(a, b, 1);
    send_beat(a[7:0],  b[7:0]);
    send_beat(a[15:8], b[15:8]);
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a     = 8'hAA;
    bus.in_b     = 8'h00;
    @(negedge clk);
    check("clear_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    check("clear_out_valid", bus.out_valid, 0);
    check("clear_state",     32'(state_dbg), 32'(IDLE));
    check("clear_op_count",  op_count, exp_ops);
    send_op(32'h0000_0002, 32'h0000_0001);
    drain();
    exp_ops++;
    check("op_count_after_clear", op_count, exp_ops);

    // Reset pulse mid-operation
    push_exp(a, b, 1);
    send_beat(a[7:0],  b[7:0]);
    send_beat(a[15:8], b[15:8]);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",   bus.in_ready,   0);
    check("mid_rst_out_valid",  bus.out_valid,  0);
    check("mid_rst_out_diff",   bus.out_diff,   0);
    check("mid_rst_out_last",   bus.out_last,   0);
    check("mid_rst_out_borrow", bus.out_borrow, 0);
    check("mid_rst_op_count",   op_count,       0);
    check("mid_rst_state",      32'(state_dbg), 32'(IDLE));
    exp_ops = 16'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_op(32'h0000_0002, 32'h0000_0001);
    drain();
    exp_ops++;
    check("op_count_after_reset", op_count, exp_ops);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sub_borrow_serial.md
# sub_borrow_serial

Byte-serial multi-word subtractor with borrow chaining. It is the inverse-direction companion of the team's add-with-carry helper. Each operation takes WORDS byte pairs, least-significant byte first, over a valid/ready stream. It returns the difference bytes on an output stream and flags the final borrow on the last beat. It sits between a byte-wide operand source and a result sink in the arithmetic exercises, and uses the same function-with-output style for the per-byte subtract.

## Interface
- WORDS, 4: bytes per operand; legal range 2..16.
- W, 8: byte width; fixed at 8 for this revision.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort of any in-progress operation.
- in_valid  input  1  operand byte pair valid.
- in_ready  output  1  block accepts a pair this cycle.
- in_a  input  8  minuend byte.
- in_b  input  8  subtrahend byte.
- out_valid  output  1  difference byte valid.
- out_ready  input  1  sink accepts a byte this cycle.
- out_diff  output  8  difference byte.
- out_last  output  1  high on the beat for byte WORDS-1.
- out_borrow  output  1  final borrow out of the full operand; valid only when out_last is high, 0 otherwise.
- op_count  output  16  number of completed operations; wraps at 0xFFFF->0.

## Operation
- Per beat: {bout, diff} = {1'b0,in_a} - {1'b0,in_b} - bin. Computed by the package function subborrow(input a, b, bin, output bout), which returns diff.
  - Beat 0: bin = 0.
  - Later beats: bin = the borrow register.
- The borrow register captures bout on every accepted beat. It clears after the last beat.
- The beat counter (0..WORDS-1) increments on each accepted beat and wraps to 0 after beat WORDS-1.
- FSM:
  - IDLE: beat counter is 0, no operation in flight. IDLE->RUN on an accepted beat when WORDS>1.
  - RUN: operation in flight. RUN->IDLE when the last beat is accepted.
  - A clear in any state returns the FSM to IDLE.
- The output register is single-entry. in_ready = !clear && (!out_valid || out_ready).
- Accepted beat (in_valid && in_ready) loads:
  - out_diff.
  - out_last = (beat == WORDS-1).
  - out_borrow = bout && out_last.
  - out_valid = 1.
- out_valid drops when out_ready is high and no new beat is accepted in the same cycle.
- op_count increments when the out_last beat is consumed (out_valid && out_ready && out_last), not when it is accepted.
- clear:
  - Zeroes the beat counter and borrow register.
  - Drops out_valid; any pending byte is discarded.
  - Returns the FSM to IDLE.
  - Leaves op_count unchanged.
  - A beat presented in the same cycle is not accepted, because in_ready is low.

## Timing
- Reset values: in_ready 0 while rst_n is low; then 1. out_valid 0, out_diff 0x00, out_last 0, out_borrow 0, op_count 0. Internally: beat 0, borrow 0, FSM IDLE.
- Latency: a beat accepted in cycle N appears on the outputs in cycle N+1.
- Throughput: one beat per cycle while out_ready is held high.
- Backpressure: out_valid high with out_ready low holds out_diff, out_last and out_borrow stable, and holds in_ready low.
- Simultaneous consume and accept: the output register reloads in the same edge and out_valid stays high.
- Reset asserted mid-operation aborts immediately (asynchronous). The next beat after reset is treated as beat 0.
- op_count wraps 0xFFFF -> 0x0000 with no flag.

## Structure
- Package sub_borrow_pkg holds:
  - function subborrow (8-bit a, b, 1-bit bin, output bout; returns the 8-bit diff).
  - typedef enum {IDLE, RUN} state_t.
  - localparam BYTE_W = 8.
- No sub-module: a single module containing the FSM, beat counter, borrow register, output register and op counter.

## Test plan
- WORDS=4, out_ready=1. Operands 0x00000005 - 0x00000003, sent as pairs (05,03),(00,00),(00,00),(00,00) -> diff 02,00,00,00; out_last only on beat 3; out_borrow 0; op_count 1.
- 0x00000100 - 0x00000001 -> diff FF,00,00,00. Borrow propagates out of byte 0 and is absorbed at byte 1. Final out_borrow 0.
- 0x00000000 - 0x00000001 -> diff FF,FF,FF,FF; out_borrow 1 on the last beat; op_count increments.
- Backpressure:
  - Hold out_ready low for 3 cycles mid-operation -> in_ready low; out_diff stable.
  - Then release -> no byte lost or duplicated; results match the unstalled run.
- Abort and restart:
  - Assert clear after beat 1 of 0x12345678 - 0x00000001, then send 0x00000002 - 0x00000001 -> diff 01,00,00,00; borrow 0; op_count advances by exactly 1.
  - Repeat with rst_n pulsed low in place of clear -> all outputs return to their reset values immediately; same result afterwards, with op_count 1.
